// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block: per-channel FSM state
// encoding and the default filter length.
package key_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    ST_UP         = 2'd0,  // stable high (released)
    ST_PRESS_FILT = 2'd1,  // low seen, qualifying the press
    ST_DOWN       = 2'd2,  // stable low (pressed)
    ST_REL_FILT   = 2'd3   // high seen, qualifying the release
  } key_state_e;

  // 20 ms at 50 MHz.
  localparam int unsigned KEY_CNT_MAX_DEFAULT = 1_000_000;
  localparam int unsigned KEY_CNT_W_DEFAULT   = 20;

endpackage

// File: rtl/key_filter.sv
// Single-channel key filter: 2-flop synchronizer followed by a 4-state
// debounce FSM with a stable-sample counter. Level and edge pulses are
// registered together so the pulse coincides with the level change.
module key_filter
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = KEY_CNT_MAX_DEFAULT,
  parameter int unsigned CNT_W   = KEY_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_o,
  output logic press_o,
  output logic rel_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  key_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       key_q, key_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;

  // Next-state logic: synchronizer shift plus debounce FSM and counter.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      ST_UP: begin
        cnt_d = CNT_ZERO;
        if (!sync2_q) begin
          state_d = ST_PRESS_FILT;
        end else begin
          state_d = ST_UP;
        end
      end
      ST_PRESS_FILT: begin
        if (sync2_q) begin
          // Bounce back to the old level: abandon the press silently.
          state_d = ST_UP;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DOWN;
          cnt_d   = CNT_ZERO;
          key_d   = 1'b0;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_DOWN: begin
        cnt_d = CNT_ZERO;
        if (sync2_q) begin
          state_d = ST_REL_FILT;
        end else begin
          state_d = ST_DOWN;
        end
      end
      ST_REL_FILT: begin
        if (!sync2_q) begin
          // Bounce back to the old level: abandon the release silently.
          state_d = ST_DOWN;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_UP;
          cnt_d   = CNT_ZERO;
          key_d   = 1'b1;
          rel_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_UP;
        cnt_d   = CNT_ZERO;
        key_d   = 1'b1;
      end
    endcase
  end

  // State register with synchronous active-low reset to the released state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_UP;
      cnt_q   <= CNT_ZERO;
      key_q   <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_o   = key_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Two-key debouncer: two fully independent key_filter channels producing
// debounced levels and one-cycle press/release pulses, all registered.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = KEY_CNT_MAX_DEFAULT,
  parameter int unsigned CNT_W   = KEY_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key1_in,
  input  logic key2_in,
  output logic key1,
  output logic key2,
  output logic key1_press,
  output logic key2_press,
  output logic key1_release,
  output logic key2_release
);

  key_filter #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_key1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key1_in),
    .key_o   (key1),
    .press_o (key1_press),
    .rel_o   (key1_release)
  );

  key_filter #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_key2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key2_in),
    .key_o   (key2),
    .press_o (key2_press),
    .rel_o   (key2_release)
  );

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce with CNT_MAX=8: directed scenarios with exact
// cycle expectations plus randomized bouncing checked against a run-length
// reference model.
module tb_key_debounce;

  localparam int CNT_MAX = 8;
  localparam int CNT_W   = 4;
  // Ticks from driving a new raw level until the output changes:
  // one tick reaches the first sampling edge, then CNT_MAX+2 more.
  localparam int LAT     = CNT_MAX + 3;
  localparam int SETTLE  = 14;

  logic clk = 1'b0;
  logic rst_n, key1_in, key2_in;
  logic key1, key2, key1_press, key2_press, key1_release, key2_release;
  logic [5:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a level is accepted once the synchronized input has
  // differed from the current output for CNT_MAX+1 consecutive samples.
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_out [2];
  logic m_press [2];
  logic m_rel [2];
  int   m_run [2];

  key_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key1_in      (key1_in),
    .key2_in      (key2_in),
    .key1         (key1),
    .key2         (key2),
    .key1_press   (key1_press),
    .key2_press   (key2_press),
    .key1_release (key1_release),
    .key2_release (key2_release)
  );

  always #5 clk = ~clk;

  assign obs = {key1, key2, key1_press, key1_release, key2_press, key2_release};

  function automatic logic [5:0] model_vec();
    return {m_out[0], m_out[1], m_press[0], m_rel[0], m_press[1], m_rel[1]};
  endfunction

  // Advance one clock, update the model with the values sampled at the edge,
  // then move 1 time unit past the edge for checking and driving.
  task automatic tick();
    logic raw [2];
    logic smp;
    @(posedge clk);
    raw[0] = key1_in;
    raw[1] = key2_in;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_out[k] = 1'b1;
        m_press[k] = 1'b0; m_rel[k] = 1'b0; m_run[k] = 0;
      end else begin
        smp = m_s2[k];
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        if (smp !== m_out[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == CNT_MAX + 1) begin
            m_out[k]   = smp;
            m_press[k] = ~smp;
            m_rel[k]   = smp;
            m_run[k]   = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = raw[k];
      end
    end
    #1;
  endtask

  task automatic settle();
    for (int i = 0; i < SETTLE; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key1_in = 1'b0; key2_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs !== 6'b110000) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b expected %b", i, obs, 6'b110000);
      end
    end
    key1_in = 1'b1; key2_in = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < SETTLE; i++) begin
      tick();
      n_tests++;
      if (obs !== 6'b110000) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs, 6'b110000);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] exp;
    key1_in = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      exp = (i < LAT) ? 6'b110000 : (i == LAT) ? 6'b011000 : 6'b010000;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL clean_press tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] exp;
    int presses = 0;
    key1_in = 1'b1;
    settle();
    key1_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) key1_in = 1'b1;
      tick();
      presses += int'(key1_press);
      n_tests++;
      if (obs !== 6'b110000) begin
        n_fail++;
        $display("FAIL bounce_quiet tick %0d: got %b expected %b", i, obs, 6'b110000);
      end
    end
    key1_in = 1'b0;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      presses += int'(key1_press);
      exp = (i < LAT) ? 6'b110000 : (i == LAT) ? 6'b011000 : 6'b010000;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL bounce_accept tick %0d: got %b expected %b", i, obs, exp);
      end
    end
    n_tests++;
    if (presses !== 1) begin
      n_fail++;
      $display("FAIL bounce_press_count: got %0d expected 1", presses);
    end
  endtask

  task automatic test_release();
    logic [5:0] exp;
    key2_in = 1'b0;
    settle();
    key2_in = 1'b1;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      exp = (i < LAT) ? 6'b000000 : (i == LAT) ? 6'b010001 : 6'b010000;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL release tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp;
    key1_in = 1'b1; key2_in = 1'b1;
    settle();
    key1_in = 1'b0; key2_in = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      exp = (i < LAT) ? 6'b110000 : (i == LAT) ? 6'b001010 : 6'b000000;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL simultaneous tick %0d: got %b expected %b", i, obs, exp);
      end
      if (i == LAT) begin
        n_tests++;
        if ((key1 & key2) !== 1'b0) begin
          n_fail++;
          $display("FAIL simultaneous_and: got %b expected 0", key1 & key2);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] exp;
    key1_in = 1'b1; key2_in = 1'b1;
    settle();
    key1_in = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (obs !== 6'b110000) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got %b expected %b", obs, 6'b110000);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      exp = (i < LAT) ? 6'b110000 : (i == LAT) ? 6'b011000 : 6'b010000;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL mid_reset_accept tick %0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    int remain [2];
    logic lvl [2];
    logic [5:0] exp;
    remain[0] = 0; remain[1] = 0;
    lvl[0] = key1_in; lvl[1] = key2_in;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (remain[k] == 0) begin
          lvl[k] = ~lvl[k];
          remain[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 16))
                                                  : int'($urandom_range(1, 10));
        end
        remain[k]--;
      end
      key1_in = lvl[0];
      key2_in = lvl[1];
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
      exp = model_vec();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b expected %b", c, obs, exp);
      end
      n_tests++;
      if (((key1_press & key1_release) | (key2_press & key2_release)) !== 1'b0) begin
        n_fail++;
        $display("FAIL random_excl cyc %0d: got press/release %b%b %b%b expected no overlap",
                 c, key1_press, key1_release, key2_press, key2_release);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_out[k] = 1'b1;
      m_press[k] = 1'b0; m_rel[k] = 1'b0; m_run[k] = 0;
    end
    rst_n = 1'b0; key1_in = 1'b1; key2_in = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
